// File: rtl/simon_game_ctrl.sv
// Simon Says game sequencer: grows the colour sequence, plays it back and checks presses.
// Optional build macro SIMON_TIMEOUT_EN adds a per-press pulse timeout in PLAYER.
module simon_game_ctrl #(
    parameter int unsigned MAX_ROUNDS     = 32,
    parameter int unsigned SPEED_STEP     = 4,
    parameter int unsigned TIMEOUT_PULSES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_game,
    input  logic       rng_valid,
    input  logic       pulse,
    input  logic       press_valid,
    input  logic [1:0] press_colour,
    input  logic [2:0] seg_colour,
    output logic       rst_seedgen,
    output logic       rng_start,
    output logic       load_colour,
    output logic       load_speed,
    output logic [2:0] speed,
    output logic       flash_colour,
    output logic [4:0] seg_idx,
    output logic       player_turn,
    output logic [5:0] round_len,
    output logic       game_over,
    output logic       game_won
);

    localparam int unsigned IDX_W = 5;
    localparam int unsigned LEN_W = 6;
    localparam int unsigned SPD_W = 3;
    localparam int unsigned CLR_W = 2;

    if (MAX_ROUNDS == 0 || MAX_ROUNDS > 32) begin : g_bad_max_rounds
        $error("MAX_ROUNDS must be in 1..32");
    end
    if (SPEED_STEP == 0 || SPEED_STEP > 63) begin : g_bad_speed_step
        $error("SPEED_STEP must be in 1..63");
    end
    if (TIMEOUT_PULSES == 0 || TIMEOUT_PULSES > 16) begin : g_bad_timeout
        $error("TIMEOUT_PULSES must be in 1..16");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_GEN,
        S_LOAD,
        S_ARM,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_PLAYER,
        S_CHECK,
        S_LOSE,
        S_WIN
    } state_t;

    state_t             state_q, state_n;
    logic [LEN_W-1:0]   round_len_n;
    logic [IDX_W-1:0]   seg_idx_n;
    logic [SPD_W-1:0]   speed_n;
    logic [CLR_W-1:0]   press_q, press_n;
    logic [LEN_W-1:0]   speed_lvl;
    logic               match;

`ifdef SIMON_TIMEOUT_EN
    logic [3:0]         to_cnt_q, to_cnt_n;
`endif

    // Next state and the values the registered outputs take on the coming edge
    always_comb begin
        state_n     = state_q;
        round_len_n = round_len;
        seg_idx_n   = seg_idx;
        speed_n     = speed;
        press_n     = press_q;
        // old round_len equals (new length - 1), the level the new round plays at
        speed_lvl   = round_len / LEN_W'(SPEED_STEP);
        match       = !seg_colour[2] && (seg_colour[1:0] == press_q);
`ifdef SIMON_TIMEOUT_EN
        to_cnt_n    = (state_q == S_PLAYER) ? to_cnt_q : 4'd0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_game) begin
                    state_n     = S_GEN;
                    round_len_n = '0;
                end
            end
            S_GEN: begin
                if (rng_valid) begin
                    state_n = S_LOAD;
                    if (round_len < LEN_W'(MAX_ROUNDS)) begin
                        round_len_n = round_len + LEN_W'(1);
                    end
                    speed_n = (speed_lvl > LEN_W'(4)) ? SPD_W'(4) : SPD_W'(speed_lvl);
                end
            end
            S_LOAD: begin
                state_n   = S_ARM;
                seg_idx_n = IDX_W'(round_len - LEN_W'(1));
            end
            S_ARM: begin
                state_n = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (pulse) begin
                    state_n = S_SHOW_OFF;
                end
            end
            S_SHOW_OFF: begin
                if (pulse) begin
                    if (seg_idx == '0) begin
                        state_n   = S_PLAYER;
                        seg_idx_n = IDX_W'(round_len - LEN_W'(1));
                    end else begin
                        state_n   = S_SHOW_ON;
                        seg_idx_n = seg_idx - IDX_W'(1);
                    end
                end
            end
            S_PLAYER: begin
                if (press_valid) begin
                    state_n = S_CHECK;
                    press_n = press_colour;
`ifdef SIMON_TIMEOUT_EN
                    to_cnt_n = 4'd0;
                end else if (pulse) begin
                    if (to_cnt_q == 4'(TIMEOUT_PULSES - 1)) begin
                        state_n = S_LOSE;
                    end else begin
                        to_cnt_n = to_cnt_q + 4'd1;
                    end
`endif
                end
            end
            S_CHECK: begin
                if (!match) begin
                    state_n = S_LOSE;
                end else if (seg_idx != '0) begin
                    state_n   = S_PLAYER;
                    seg_idx_n = seg_idx - IDX_W'(1);
                end else if (round_len == LEN_W'(MAX_ROUNDS)) begin
                    state_n = S_WIN;
                end else begin
                    state_n = S_GEN;
                end
            end
            S_LOSE, S_WIN: begin
                if (start_game) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Registered state, datapath and outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            press_q      <= '0;
            round_len    <= '0;
            seg_idx      <= '0;
            speed        <= '0;
            rst_seedgen  <= 1'b0;
            rng_start    <= 1'b0;
            load_colour  <= 1'b0;
            load_speed   <= 1'b0;
            flash_colour <= 1'b0;
            player_turn  <= 1'b0;
            game_over    <= 1'b0;
            game_won     <= 1'b0;
        end else begin
            state_q      <= state_n;
            press_q      <= press_n;
            round_len    <= round_len_n;
            seg_idx      <= seg_idx_n;
            speed        <= speed_n;
            rst_seedgen  <= ((state_n == S_LOSE) && (state_q != S_LOSE)) ||
                            ((state_n == S_WIN)  && (state_q != S_WIN));
            rng_start    <= (state_n == S_GEN);
            load_colour  <= (state_n == S_LOAD);
            load_speed   <= (state_n == S_ARM);
            flash_colour <= (state_n == S_SHOW_ON);
            player_turn  <= (state_n == S_PLAYER);
            game_over    <= (state_n == S_LOSE);
            game_won     <= (state_n == S_WIN);
        end
    end

`ifdef SIMON_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= 4'd0;
        end else begin
            to_cnt_q <= to_cnt_n;
        end
    end
`endif

endmodule
